// File: rtl/tt_pll_pkg.sv
// Shared PLL types: scan sequencer state encoding, command encoding and the
// loop-filter accumulator width used as the default scan chain length.
package tt_pll_pkg;

  localparam int LPF_ACC_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GUARD,
    S_DONE
  } scan_state_e;

  typedef enum logic {
    SCAN_READ  = 1'b0,
    SCAN_WRITE = 1'b1
  } scan_cmd_e;

endpackage

// File: rtl/tt_lpf_scan_ctrl.sv
// Loop-filter integrator scan sequencer. One command at a time takes the
// filter's scan chain for CHAIN_LEN shift cycles: WRITE loads a new value and
// returns the old one, READ rotates the chain so the value is preserved and
// returns a copy. A short guard window with scan_en low follows each shift so
// the filter control path settles before o_done.
module tt_lpf_scan_ctrl
  import tt_pll_pkg::*;
#(
  parameter int CHAIN_LEN    = LPF_ACC_W,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                 i_clk_gen,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [CHAIN_LEN-1:0] i_req_wdata,
  output logic [CHAIN_LEN-1:0] o_rdata,
  output logic                 o_done,
  output logic                 o_busy,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  input  logic                 i_scan_out
);

  // Shift counter has one spare bit so CHAIN_LEN-1 never wraps mid-command.
  localparam int CNT_W  = $clog2(CHAIN_LEN) + 1;
  // Guard counter sized so it stays at least 1 bit wide when GUARD_CYCLES=0.
  localparam int GCNT_W = $clog2(GUARD_CYCLES + 1) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GUARD_CYCLES - 1);

  scan_state_e            state_reg, state_next;
  scan_cmd_e              cmd_reg, cmd_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [GCNT_W-1:0]      gcnt_reg, gcnt_next;
  logic [CHAIN_LEN-1:0]   sreg_reg, sreg_next;
  logic [CHAIN_LEN-1:0]   rdata_reg, rdata_next;
  logic                   scan_en_reg, scan_en_next;

  // State register and datapath registers; reset returns everything to idle/zero.
  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      cmd_reg     <= SCAN_READ;
      cnt_reg     <= '0;
      gcnt_reg    <= '0;
      sreg_reg    <= '0;
      rdata_reg   <= '0;
      scan_en_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cmd_reg     <= cmd_next;
      cnt_reg     <= cnt_next;
      gcnt_reg    <= gcnt_next;
      sreg_reg    <= sreg_next;
      rdata_reg   <= rdata_next;
      scan_en_reg <= scan_en_next;
    end
  end

  // Next-state logic: accept in IDLE, shift CHAIN_LEN bits, guard, then pulse done.
  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    cnt_next     = cnt_reg;
    gcnt_next    = gcnt_reg;
    sreg_next    = sreg_reg;
    rdata_next   = rdata_reg;
    scan_en_next = scan_en_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_req_valid) begin
          cmd_next     = scan_cmd_e'(i_req_write);
          sreg_next    = i_req_wdata;
          scan_en_next = 1'b1;
          cnt_next     = '0;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Integrator MSB comes out first, so the capture shifts in from the LSB.
        rdata_next = {rdata_reg[CHAIN_LEN-2:0], i_scan_out};
        if (cmd_reg == SCAN_WRITE) begin
          sreg_next = sreg_reg << 1;
        end
        if (cnt_reg == CNT_LAST) begin
          scan_en_next = 1'b0;
          gcnt_next    = '0;
          state_next   = (GUARD_CYCLES == 0) ? S_DONE : S_GUARD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GUARD: begin
        if (gcnt_reg == GCNT_LAST) begin
          state_next = S_DONE;
        end else begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Scan data into the filter: new value MSB-first on WRITE, loop-back on READ.
  always_comb begin
    o_scan_in = 1'b0;
    if (state_reg == S_SHIFT) begin
      o_scan_in = (cmd_reg == SCAN_WRITE) ? sreg_reg[CHAIN_LEN-1] : i_scan_out;
    end
  end

  assign o_req_ready = (state_reg == S_IDLE);
  assign o_busy      = (state_reg != S_IDLE);
  assign o_done      = (state_reg == S_DONE);
  assign o_scan_en   = scan_en_reg;
  assign o_rdata     = rdata_reg;

endmodule

// File: tb/tb_tt_lpf_scan_ctrl.sv
// Bench for tt_lpf_scan_ctrl: two instances (GUARD_CYCLES=2 and 0), each
// attached to a behavioural model of the loop-filter integrator scan chain.
// Expected read data goes to a per-instance queue at accept and is compared
// when o_done pulses.
module tb_tt_lpf_scan_ctrl;

  localparam int W = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [W-1:0]     req_wdata [2];
  logic [W-1:0]     rdata [2];
  logic [1:0]       done;
  logic [1:0]       busy;
  logic [1:0]       scan_en;
  logic [1:0]       scan_in;
  logic [1:0]       scan_out;

  // Integrator model: preload port plus scan shift (MSB out, scan_in into LSB).
  logic [W-1:0]     acc [2];
  logic [1:0]       load_en;
  logic [W-1:0]     load_val [2];

  int checks;
  int failures;

  logic [W-1:0] sb_q0[$];
  logic [W-1:0] sb_q1[$];

  typedef struct {
    logic         wr;
    logic [W-1:0] wdata;
    logic [W-1:0] acc0;
    logic [W-1:0] exp_rd;
    logic [W-1:0] exp_acc;
  } vec_t;

  vec_t vecs [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tt_lpf_scan_ctrl #(.CHAIN_LEN(W), .GUARD_CYCLES(2)) dut0 (
    .i_clk_gen   (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid[0]),
    .o_req_ready (req_ready[0]),
    .i_req_write (req_write[0]),
    .i_req_wdata (req_wdata[0]),
    .o_rdata     (rdata[0]),
    .o_done      (done[0]),
    .o_busy      (busy[0]),
    .o_scan_en   (scan_en[0]),
    .o_scan_in   (scan_in[0]),
    .i_scan_out  (scan_out[0])
  );

  tt_lpf_scan_ctrl #(.CHAIN_LEN(W), .GUARD_CYCLES(0)) dut1 (
    .i_clk_gen   (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid[1]),
    .o_req_ready (req_ready[1]),
    .i_req_write (req_write[1]),
    .i_req_wdata (req_wdata[1]),
    .o_rdata     (rdata[1]),
    .o_done      (done[1]),
    .o_busy      (busy[1]),
    .o_scan_en   (scan_en[1]),
    .o_scan_in   (scan_in[1]),
    .i_scan_out  (scan_out[1])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_en[i]) acc[i] <= load_val[i];
      else if (scan_en[i]) acc[i] <= {acc[i][W-2:0], scan_in[i]};
    end
  end

  assign scan_out[0] = acc[0][W-1];
  assign scan_out[1] = acc[1][W-1];

  task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: every o_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done[0]) begin
      if (sb_q0.size() == 0) begin
        check_int("dut0_unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = sb_q0.pop_front();
        check32("dut0_rdata", rdata[0], e);
        $display("txn dut0 rdata=%h expected=%h", rdata[0], e);
      end
    end
    if (!rst && done[1]) begin
      if (sb_q1.size() == 0) begin
        check_int("dut1_unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = sb_q1.pop_front();
        check32("dut1_rdata", rdata[1], e);
        $display("txn dut1 rdata=%h expected=%h", rdata[1], e);
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic preload(input int inst, input logic [W-1:0] v);
    load_en[inst]  = 1'b1;
    load_val[inst] = v;
    @(negedge clk);
    load_en[inst]  = 1'b0;
  endtask

  // Issue one command; cycle 0 is the accept cycle. After accept the request
  // inputs are scrambled to show they are only sampled at accept.
  task automatic run_cmd(input int inst, input logic wr, input logic [W-1:0] wd,
                         input logic [W-1:0] exp_rd, output int done_cyc,
                         output int ready_cyc, output int en_cnt, output int busy_cnt);
    int cyc;
    int waitc;
    done_cyc  = -1;
    ready_cyc = -1;
    en_cnt    = 0;
    busy_cnt  = 0;
    req_valid[inst] = 1'b1;
    req_write[inst] = wr;
    req_wdata[inst] = wd;
    waitc = 0;
    while (!req_ready[inst] && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (inst == 0) sb_q0.push_back(exp_rd);
    else sb_q1.push_back(exp_rd);
    @(negedge clk);
    req_valid[inst] = 1'b0;
    req_write[inst] = ~wr;
    req_wdata[inst] = ~wd;
    cyc = 1;
    forever begin
      if (scan_en[inst]) en_cnt++;
      if (busy[inst]) busy_cnt++;
      if (done[inst] && done_cyc < 0) done_cyc = cyc;
      if (req_ready[inst]) begin
        ready_cyc = cyc;
        break;
      end
      if (cyc >= 200) begin
        check_int("cmd_timeout", cyc, -1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int dc, rc, ec, bc, cyc, ndone;
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_wdata[0] = '0;
    req_wdata[1] = '0;
    load_en   = '0;
    load_val[0] = '0;
    load_val[1] = '0;

    vecs[0] = '{wr: 1'b1, wdata: 32'hDEADBEEF, acc0: 32'h00000005, exp_rd: 32'h00000005, exp_acc: 32'hDEADBEEF};
    vecs[1] = '{wr: 1'b0, wdata: 32'h00000000, acc0: 32'h1234ABCD, exp_rd: 32'h1234ABCD, exp_acc: 32'h1234ABCD};
    vecs[2] = '{wr: 1'b1, wdata: 32'h00000000, acc0: 32'hFFFFFFFF, exp_rd: 32'hFFFFFFFF, exp_acc: 32'h00000000};
    vecs[3] = '{wr: 1'b0, wdata: 32'hFFFFFFFF, acc0: 32'hA5A55A5A, exp_rd: 32'hA5A55A5A, exp_acc: 32'hA5A55A5A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_int("reset_ready", int'(req_ready[0]), 1);
    check_int("reset_scan_en", int'(scan_en[0]), 0);
    check_int("reset_busy", int'(busy[0]), 0);
    check_int("reset_done", int'(done[0]), 0);
    check32("reset_rdata", rdata[0], 32'h0);

    // Table vectors on the GUARD_CYCLES=2 instance.
    for (int i = 0; i < 4; i++) begin
      preload(0, vecs[i].acc0);
      run_cmd(0, vecs[i].wr, vecs[i].wdata, vecs[i].exp_rd, dc, rc, ec, bc);
      check32("vec_acc_after", acc[0], vecs[i].exp_acc);
      check_int("vec_scan_en_cycles", ec, 32);
      check_int("vec_done_cycle", dc, 35);
      check_int("vec_ready_cycle", rc, 36);
      check_int("vec_busy_cycles", bc, 35);
    end

    // Zero-guard latency on the second instance.
    preload(1, 32'h0BADF00D);
    run_cmd(1, 1'b0, 32'h0, 32'h0BADF00D, dc, rc, ec, bc);
    check_int("g0_done_cycle", dc, 33);
    check_int("g0_ready_cycle", rc, 34);
    check_int("g0_scan_en_cycles", ec, 32);
    check32("g0_acc_after", acc[1], 32'h0BADF00D);

    // Request held while busy: second command waits for ready.
    preload(0, 32'h0F0F0F0F);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_wdata[0] = 32'h0;
    sb_q0.push_back(32'h0F0F0F0F);
    @(negedge clk);
    req_write[0] = 1'b1;
    req_wdata[0] = 32'hFFFFFFFF;
    sb_q0.push_back(32'h0F0F0F0F);
    cyc = 1;
    while (!req_ready[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_int("busy_second_accept_cycle", cyc, 36);
    @(negedge clk);
    req_valid[0] = 1'b0;
    cyc = 0;
    while (!req_ready[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_int("busy_second_ready_cycle", cyc, 35);
    check32("busy_acc_after", acc[0], 32'hFFFFFFFF);
    check_int("busy_queue_empty", sb_q0.size(), 0);

    // Reset in the middle of shifting: scan_en drops, rdata clears, no done.
    preload(0, 32'hFFFFFFFF);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_int("pre_reset_scan_en", int'(scan_en[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_int("midreset_scan_en", int'(scan_en[0]), 0);
    check32("midreset_rdata", rdata[0], 32'h0);
    check_int("midreset_ready", int'(req_ready[0]), 1);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done[0]) ndone++;
      @(negedge clk);
    end
    check_int("midreset_no_done", ndone, 0);

    // Back-to-back WRITE then READ returns the written value.
    preload(0, 32'h00000000);
    run_cmd(0, 1'b1, 32'h80000001, 32'h00000000, dc, rc, ec, bc);
    run_cmd(0, 1'b0, 32'h0, 32'h80000001, dc, rc, ec, bc);
    check32("b2b_acc_after", acc[0], 32'h80000001);
    check_int("b2b_queue_empty", sb_q0.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
